// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Glyphs are active-low cathode patterns ordered {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_display_scan_if.sv
// Display data in, anode/cathode pins out; the driver sits on the slave side.
interface hex_display_scan_if;

  logic [31:0] disp_data;
  logic        lz_en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output disp_data, lz_en, input an, seg, dp);
  modport slave  (input disp_data, lz_en, output an, seg, dp);

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[nibble];
  end

endmodule

// File: rtl/hex_display_scan.sv
// Eight-digit multiplexed display scanner with inter-digit blanking,
// per-scan snapshot of the data word and optional leading-zero blanking.
module hex_display_scan
  import display_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic                clock,
  input  logic                reset_n,
  hex_display_scan_if.slave   bus
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS);

  scan_state_t      state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [2:0]       dig, next_dig;
  logic [31:0]      snap;
  logic             snap_lz;
  logic             capture;
  logic [7:0]       an_q, next_an;
  logic [6:0]       seg_q, next_seg;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic [7:0]       sup_mask;
  logic             zero_above;

  // On the capture edge snap is still stale, so digit 0 decodes the live word.
  always_comb begin
    nibble = capture ? bus.disp_data[3:0] : snap[{dig, 2'b00} +: 4];
  end

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    zero_above = 1'b1;
    sup_mask   = '0;
    for (int k = 7; k >= 1; k--) begin
      zero_above  = zero_above & (snap[4*k +: 4] == 4'h0);
      sup_mask[k] = snap_lz & zero_above;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt + 1'b1;
    next_dig   = dig;
    next_an    = an_q;
    next_seg   = seg_q;
    capture    = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CNT_W'(BLANK_TICKS - 1)) begin
          next_state = SHOW;
          next_cnt   = '0;
          capture    = (dig == 3'd0);
          next_an    = ~(8'b1 << dig);
          next_seg   = sup_mask[dig] ? SEG_BLANK : glyph;
        end
      end
      SHOW: begin
        if (cnt == CNT_W'(DIGIT_TICKS - 1)) begin
          next_state = BLANK;
          next_cnt   = '0;
          next_dig   = dig + 3'd1;
          next_an    = AN_OFF;
          next_seg   = SEG_BLANK;
        end
      end
      default: begin
        next_state = BLANK;
        next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= BLANK;
      cnt     <= '0;
      dig     <= '0;
      snap    <= '0;
      snap_lz <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      dig   <= next_dig;
      an_q  <= next_an;
      seg_q <= next_seg;
      if (capture) begin
        snap    <= bus.disp_data;
        snap_lz <= bus.lz_en;
      end
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with short tick counts; expected
// glyphs and timing are hand-computed from the glyph table.
module tb_hex_display_scan;

  localparam int DT = 4;
  localparam int BT = 2;

  logic clock = 1'b0;
  logic reset_n;
  int   testsRun    = 0;
  int   testsFailed = 0;

  hex_display_scan_if bus ();

  hex_display_scan #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic lz);
    bus.disp_data = data;
    bus.lz_en     = lz;
  endtask

  // Starts on the first cycle of digit 0's blank gap and ends on the next one.
  task automatic checkScan(input string name, input logic [55:0] expSegs,
                           input int changeDig, input logic [31:0] changeVal);
    logic [7:0] expAn;
    for (int k = 0; k < 8; k++) begin
      expAn = ~(8'b1 << k);
      for (int b = 0; b < BT; b++) begin
        checkOutput($sformatf("%s d%0d gap%0d an", name, k, b), bus.an, 8'hFF);
        checkOutput($sformatf("%s d%0d gap%0d seg", name, k, b), bus.seg, 7'h7F);
        @(negedge clock);
      end
      for (int d = 0; d < DT; d++) begin
        if (k == changeDig && d == 0) bus.disp_data = changeVal;
        checkOutput($sformatf("%s d%0d lit%0d an", name, k, d), bus.an, expAn);
        checkOutput($sformatf("%s d%0d lit%0d seg", name, k, d), bus.seg, expSegs[k*7 +: 7]);
        checkOutput($sformatf("%s d%0d lit%0d dp", name, k, d), bus.dp, 1'b1);
        @(negedge clock);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic prevLit;
    logic lit;
    int   runLen;

    reset_n = 1'b0;
    applyStimulus(32'h0, 1'b0);
    repeat (3) begin
      @(negedge clock);
      checkOutput("reset an", bus.an, 8'hFF);
      checkOutput("reset seg", bus.seg, 7'h7F);
      checkOutput("reset dp", bus.dp, 1'b1);
    end

    applyStimulus(32'h76543210, 1'b0);
    reset_n = 1'b1;
    checkScan("first", {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, -1, 32'h0);

    applyStimulus(32'hFFFFFFFF, 1'b0);
    checkScan("tear", {8{7'h0E}}, 3, 32'h00000000);
    checkScan("after tear", {8{7'h40}}, -1, 32'h0);

    applyStimulus(32'h00000A05, 1'b1);
    checkScan("lz", {{5{7'h7F}}, 7'h08, 7'h40, 7'h12}, -1, 32'h0);
    applyStimulus(32'h00000000, 1'b1);
    checkScan("lz zero", {{7{7'h7F}}, 7'h40}, -1, 32'h0);

    applyStimulus(32'hFEDCBA98, 1'b0);
    checkScan("glyph hi", {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, -1, 32'h0);
    applyStimulus(32'h76543210, 1'b0);
    checkScan("glyph lo", {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, -1, 32'h0);

    repeat (5 * (BT + DT) + BT) @(negedge clock);
    checkOutput("mid d5 an", bus.an, 8'hDF);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset an", bus.an, 8'hFF);
    checkOutput("async reset seg", bus.seg, 7'h7F);
    @(negedge clock);
    applyStimulus(32'h89ABCDEF, 1'b0);
    reset_n = 1'b1;
    checkScan("restart", {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, -1, 32'h0);

    prevLit = 1'b0;
    runLen  = 0;
    for (int s = 0; s < 10; s++) begin
      applyStimulus($urandom, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 8 * (BT + DT); c++) begin
        lit = (bus.an != 8'hFF);
        checkOutput("inv one anode", 32'($countones(~bus.an) <= 1), 32'd1);
        checkOutput("inv dp", bus.dp, 1'b1);
        if (runLen == 0 || lit == prevLit) begin
          runLen++;
        end else begin
          checkOutput(prevLit ? "inv lit window" : "inv gap", runLen, prevLit ? DT : BT);
          prevLit = lit;
          runLen  = 1;
        end
        @(negedge clock);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. Consumes the 32-bit `disp_data` word from the register file (low nibbles of r0..r7, r0 in bits [3:0]) and scans one hex digit at a time. It inserts a blanking gap between digits to suppress ghosting. It snapshots the word once per full scan so a displayed frame never tears.

## Interface
- `DIGIT_TICKS`, default 100000: clock cycles each digit is lit. Minimum 2.
- `BLANK_TICKS`, default 1000: clock cycles all anodes are off between digits. Minimum 1.
- `clock`  in  1: system clock. All state changes on the rising edge.
- `reset_n`  in  1: one clock; reset is asynchronous and active-low.
- `disp_data`  in  32: eight hex nibbles. Digit k is `disp_data[4k+3:4k]`.
- `lz_en`  in  1: leading-zero suppression enable. Sampled together with the snapshot.
- `an`  out  8: anode enables, active-low. `an[k]` selects digit k.
- `seg`  out  7: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  out  1: decimal point, active-low. Tied off (constant 1).

## Operation
- Two-state FSM:
  - BLANK: `an`=8'hFF, `seg`=7'h7F.
  - SHOW: `an` has exactly one bit low, at the current digit index `dig` (0..7).
- Tick counter `cnt`:
  - Cleared on every state transition.
  - BLANK lasts exactly BLANK_TICKS cycles; SHOW lasts exactly DIGIT_TICKS cycles.
- Transitions:
  - BLANK→SHOW when `cnt`==BLANK_TICKS-1.
  - SHOW→BLANK when `cnt`==DIGIT_TICKS-1. On this transition `dig` increments and wraps 7→0.
- Snapshot:
  - On the BLANK→SHOW edge with `dig`==0, the block captures `disp_data` and `lz_en` into `snap` and `snap_lz`.
  - Digits 0..7 of that scan all show `snap`. Changes to `disp_data` mid-scan appear only in the next scan.
  - The digit-0 segments shown on the capture edge are decoded from the value being captured.
- Decode, hex glyph per nibble:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero suppression:
  - Applies when `snap_lz`=1, to digit k>0 when nibble k and every higher nibble are zero.
  - Such a digit shows `seg`=7'h7F, with its anode still driven low so the timing is unchanged.
  - Digit 0 is never suppressed.
- Outputs:
  - `an` and `seg` are registered. No combinational path from `disp_data` to the pins.
  - `dp` is constant 1.

## Timing
- Reset values while `reset_n`=0: state=BLANK, `cnt`=0, `dig`=0, `snap`=0, `snap_lz`=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- After reset deassertion:
  - First BLANK phase is BLANK_TICKS cycles.
  - Digit 0 lights on the following edge.
- Per-digit period = BLANK_TICKS+DIGIT_TICKS. Full scan = 8×(BLANK_TICKS+DIGIT_TICKS) cycles.
- Output latency: `an`/`seg` change on the same edge as the state transition that causes them. No extra pipeline cycle.
- At no edge do two anodes go low together.
- A lit→lit transition never happens without at least BLANK_TICKS cycles of all-off in between.
- Reset asserted mid-SHOW: `an` returns to 8'hFF asynchronously. The scan restarts at digit 0 with a fresh snapshot.
- Counter width is $clog2(max(DIGIT_TICKS,BLANK_TICKS)). It must not overflow at DIGIT_TICKS=100000.

## Structure
- Package `display_pkg`:
  - state encoding (BLANK, SHOW)
  - `SEG_BLANK`=7'h7F and `AN_OFF`=8'hFF
  - the 16-entry glyph constants
- Sub-module `hex_to_seg7`: combinational 4-bit→7-bit active-low decoder. Instantiated once, fed by a nibble mux.
- Top: FSM, counter, digit index, snapshot register, suppression mask (8-bit, computed from `snap` and `snap_lz`), output registers.

## Test plan
Run with DIGIT_TICKS=4 and BLANK_TICKS=2.
1. **Reset and first scan.** Hold `reset_n`=0 for 3 cycles, then release with `disp_data`=32'h76543210.
   - `an`=FF and `seg`=7F during reset and for 2 cycles after release.
   - Then `an`=FE with `seg`=40 for 4 cycles, 2 blank cycles, then `an`=FD with `seg`=79.
   - Digit 7 shows `seg`=78. The full scan takes 48 cycles.
2. **Snapshot, no tearing.** `disp_data`=32'hFFFFFFFF; change it to 32'h00000000 while digit 3 is lit.
   - Digits 4..7 still show 0E.
   - The next scan shows 40 on all digits.
3. **Leading-zero suppression.** `lz_en`=1, `disp_data`=32'h00000A05.
   - Digit 0 shows 12, digit 1 shows 40 (interior zero kept), digit 2 shows 08.
   - Digits 3..7 show 7F with their anodes low in turn.
   - All-zero input shows 40 on digit 0 only.
4. **Full glyph coverage.** `disp_data`=32'hFEDCBA98 and then 32'h76543210. Check every digit against the 16-entry glyph list.
5. **Mid-operation reset.** Assert `reset_n`=0 asynchronously while digit 5 is lit.
   - `an`=FF before the next clock edge.
   - After release, the scan restarts at digit 0 after exactly 2 blank cycles.
6. **Invariant check.** Over 10 random scans, verify:
   - `an` never has more than one zero bit;
   - `dp`≡1;
   - each lit window is exactly 4 cycles and each gap exactly 2.
